// File: rtl/alu_share_arbiter.sv
// Two requesters share one external combinational alu. Round-robin issue into a single
// stage register that drives the alu; results land in a one-entry buffer per requester.
package riscv_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;
endpackage

module alu_share_arbiter
  import riscv_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  alu_op_t          req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  alu_op_t          req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic             rsp0_zero,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic             rsp1_zero,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output alu_op_t          alu_op,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             idle
);

  logic             s1_v_q, s1_v_d;
  logic [31:0]      s1_a_q, s1_a_d;
  logic [31:0]      s1_b_q, s1_b_d;
  alu_op_t          s1_op_q, s1_op_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s1_own_q, s1_own_d;
  logic [1:0]       r_v_q, r_v_d;
  logic [31:0]      r_res_q [2];
  logic [31:0]      r_res_d [2];
  logic [1:0]       r_zero_q, r_zero_d;
  logic [TAG_W-1:0] r_tag_q [2];
  logic [TAG_W-1:0] r_tag_d [2];
  logic             rr_q, rr_d;

  logic [1:0]       drain;
  logic [1:0]       acc;
  logic             advance;
  logic             can_load;

  // Handshakes, round-robin grant, and next state of issue stage and response buffers.
  always_comb begin
    drain    = r_v_q & {rsp1_ready, rsp0_ready};
    advance  = s1_v_q && (!r_v_q[s1_own_q] || drain[s1_own_q]);
    can_load = !s1_v_q || advance;
    // Each ready looks only at the other requester's valid and the rr pointer.
    req0_ready = !rst && can_load && (!req1_valid || rr_q);
    req1_ready = !rst && can_load && (!req0_valid || !rr_q);
    acc        = {req1_valid && req1_ready, req0_valid && req0_ready};

    s1_v_d   = s1_v_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_op_d  = s1_op_q;
    s1_tag_d = s1_tag_q;
    s1_own_d = s1_own_q;
    rr_d     = rr_q;
    r_v_d    = r_v_q;
    r_zero_d = r_zero_q;
    r_res_d  = r_res_q;
    r_tag_d  = r_tag_q;

    if (acc[0]) begin
      s1_v_d   = 1'b1;
      s1_a_d   = req0_a;
      s1_b_d   = req0_b;
      s1_op_d  = req0_op;
      s1_tag_d = req0_tag;
      s1_own_d = 1'b0;
      rr_d     = 1'b0;
    end else if (acc[1]) begin
      s1_v_d   = 1'b1;
      s1_a_d   = req1_a;
      s1_b_d   = req1_b;
      s1_op_d  = req1_op;
      s1_tag_d = req1_tag;
      s1_own_d = 1'b1;
      rr_d     = 1'b1;
    end else if (advance) begin
      s1_v_d = 1'b0;
    end else begin
      s1_v_d = s1_v_q;
    end

    // A refill on the same edge as a drain keeps the buffer valid.
    for (int i = 0; i < 2; i++) begin
      if (advance && (s1_own_q == 1'(i))) begin
        r_v_d[i]    = 1'b1;
        r_res_d[i]  = alu_result;
        r_zero_d[i] = alu_zero;
        r_tag_d[i]  = s1_tag_q;
      end else if (drain[i]) begin
        r_v_d[i] = 1'b0;
      end else begin
        r_v_d[i] = r_v_q[i];
      end
    end
  end

  // State registers; reset drops every in-flight op and makes req0 win first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_a_q     <= 32'd0;
      s1_b_q     <= 32'd0;
      s1_op_q    <= ALU_ADD;
      s1_tag_q   <= '0;
      s1_own_q   <= 1'b0;
      rr_q       <= 1'b1;
      r_v_q      <= 2'b00;
      r_zero_q   <= 2'b00;
      r_res_q[0] <= 32'd0;
      r_res_q[1] <= 32'd0;
      r_tag_q[0] <= '0;
      r_tag_q[1] <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_op_q  <= s1_op_d;
      s1_tag_q <= s1_tag_d;
      s1_own_q <= s1_own_d;
      rr_q     <= rr_d;
      r_v_q    <= r_v_d;
      r_zero_q <= r_zero_d;
      r_res_q  <= r_res_d;
      r_tag_q  <= r_tag_d;
    end
  end

  assign alu_a       = s1_a_q;
  assign alu_b       = s1_b_q;
  assign alu_op      = s1_op_q;
  assign rsp0_valid  = r_v_q[0];
  assign rsp0_result = r_res_q[0];
  assign rsp0_zero   = r_zero_q[0];
  assign rsp0_tag    = r_tag_q[0];
  assign rsp1_valid  = r_v_q[1];
  assign rsp1_result = r_res_q[1];
  assign rsp1_zero   = r_zero_q[1];
  assign rsp1_tag    = r_tag_q[1];
  assign idle        = !s1_v_q && !r_v_q[0] && !r_v_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic; a monitor compares
// every presented response against per-requester queues filled at accept time.
module tb_alu_share_arbiter;
  import riscv_pkg::*;
  localparam int TAG_W = 4;

  typedef struct {
    logic [31:0]      res;
    logic             zero;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  alu_op_t          req0_op, req1_op;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0]      rsp0_result, rsp1_result;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;
  logic [31:0]      alu_a, alu_b, alu_result;
  alu_op_t          alu_op;
  logic             alu_zero;
  logic             idle;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_acc [2] = '{0, 0};
  int n_rsp [2] = '{0, 0};
  int lost  [2] = '{0, 0};
  exp_t q0[$];
  exp_t q1[$];
  int grant_q[$];
  int acc_cyc_q[$];
  logic [1:0]       acc_last = 2'b00;
  logic [1:0]       shown = 2'b00;
  logic             last_win = 1'b1;
  bit               chk_lat = 1'b0;
  logic [31:0]      last_res  [2];
  logic             last_zero [2];
  logic [TAG_W-1:0] last_tag  [2];

  alu_share_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_tag(rsp1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_zero(alu_zero), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << b[4:0];
      4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> b[4:0];
      4'd7: return 32'($signed(a) >>> b[4:0]);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // The shared alu that sits outside the arbiter.
  always_comb begin
    alu_result = alu_fn(alu_a, alu_b, alu_op);
    alu_zero   = (alu_result == 32'd0);
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endfunction

  function automatic void fail_evt(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: actual event occurred, required none", nm);
  endfunction

  task automatic mon_rsp(input int i, input logic v, input logic r, input logic [31:0] res,
                         input logic z, input logic [TAG_W-1:0] tag);
    exp_t e;
    int   sz;
    sz = (i == 0) ? q0.size() : q1.size();
    if (v) begin
      if (sz == 0) begin
        fail_evt($sformatf("rsp%0d_unexpected", i));
      end else begin
        if (i == 0) e = q0[0];
        else        e = q1[0];
        chk($sformatf("rsp%0d_result", i), res, e.res);
        chk($sformatf("rsp%0d_zero", i), z, e.zero);
        chk($sformatf("rsp%0d_tag", i), tag, e.tag);
        if (!shown[i]) begin
          if (chk_lat) chk($sformatf("rsp%0d_latency", i), 64'(cyc - e.acc), 64'd2);
          else if (cyc - e.acc < 2) fail_evt($sformatf("rsp%0d_too_early", i));
        end
        if (r) begin
          if (i == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
          n_rsp[i]++;
          last_res[i]  = res;
          last_zero[i] = z;
          last_tag[i]  = tag;
        end
      end
    end
    shown[i] = v && !r;
  endtask

  task automatic mon_acc();
    logic a0, a1;
    exp_t e;
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    acc_last = {a1, a0};
    if (a0 && a1) fail_evt("double_grant");
    if (req0_valid && req1_valid && (a0 || a1)) chk("rr_grant", a1, !last_win);
    if (a0 || a1) last_win = a1;
    if (req0_valid && a1) lost[0]++;
    else if (a0) lost[0] = 0;
    if (req1_valid && a0) lost[1]++;
    else if (a1) lost[1] = 0;
    for (int i = 0; i < 2; i++) begin
      if (lost[i] > 1) begin
        fail_evt($sformatf("starve%0d", i));
        lost[i] = 0;
      end
    end
    if (a0) begin
      e.res = alu_fn(req0_a, req0_b, req0_op);
      e.zero = (e.res == 32'd0);
      e.tag = req0_tag;
      e.acc = cyc;
      q0.push_back(e);
      n_acc[0]++;
      grant_q.push_back(0);
      acc_cyc_q.push_back(cyc);
    end
    if (a1) begin
      e.res = alu_fn(req1_a, req1_b, req1_op);
      e.zero = (e.res == 32'd0);
      e.tag = req1_tag;
      e.acc = cyc;
      q1.push_back(e);
      n_acc[1]++;
      grant_q.push_back(1);
      acc_cyc_q.push_back(cyc);
    end
  endtask

  // Monitor: samples just before each rising edge; reset forgets every in-flight op.
  always @(negedge clk) begin
    #4;
    cyc++;
    if (rst) begin
      q0.delete();
      q1.delete();
      n_acc[0] = n_rsp[0];
      n_acc[1] = n_rsp[1];
      last_win = 1'b1;
      lost     = '{0, 0};
      shown    = 2'b00;
      acc_last = 2'b00;
    end else begin
      mon_rsp(0, rsp0_valid, rsp0_ready, rsp0_result, rsp0_zero, rsp0_tag);
      mon_rsp(1, rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero, rsp1_tag);
      mon_acc();
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input alu_op_t op, input logic [TAG_W-1:0] tag);
    if (i == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; req0_tag = tag;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; req1_tag = tag;
    end
  endtask

  task automatic clr_req(input int i);
    if (i == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  function automatic int cnt_of(input bit rsp, input int i);
    return rsp ? n_rsp[i] : n_acc[i];
  endfunction

  task automatic wait_cnt(input string nm, input bit rsp, input int i, input int target,
                          input int budget);
    int k;
    k = 0;
    while (cnt_of(rsp, i) < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 64'(cnt_of(rsp, i) >= target), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(3))
      0: return 32'd0;
      1: return 32'($urandom_range(3));
      2: return 32'hFFFF_FFFF - 32'($urandom_range(3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int b0, b1, k;
    int idx [2];
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_op = ALU_ADD; req0_tag = '0;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_op = ALU_ADD; req1_tag = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_idle", idle, 1'b1);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    chk("rst_alu_op", alu_op, ALU_ADD);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single ADD from req0, responses always accepted.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1; chk_lat = 1'b1;
    set_req(0, 32'd5, 32'd7, ALU_ADD, 4'd3);
    wait_cnt("t1_acc", 1'b0, 0, 1, 10);
    clr_req(0);
    wait_cnt("t1_rsp", 1'b1, 0, 1, 10);
    chk("t1_result", last_res[0], 32'd12);
    chk("t1_zero", last_zero[0], 1'b0);
    chk("t1_tag", last_tag[0], 4'd3);
    chk("t1_no_rsp1", 64'(n_rsp[1]), 64'd0);

    // Continuous contention from reset: strict alternation, one issue per cycle.
    do_reset();
    grant_q.delete(); acc_cyc_q.delete();
    b0 = n_rsp[0]; b1 = n_rsp[1]; idx = '{0, 0}; k = 0;
    while ((n_rsp[0] < b0 + 4 || n_rsp[1] < b1 + 4) && k < 40) begin
      for (int i = 0; i < 2; i++) begin
        if (acc_last[i]) idx[i]++;
        if (idx[i] < 4)
          set_req(i, 32'(100 * (i + 1) + idx[i]), 32'(idx[i]),
                  (idx[i] % 2 == 1) ? ALU_XOR : ALU_ADD, 4'(8 * i + idx[i]));
        else
          clr_req(i);
      end
      @(negedge clk);
      k++;
    end
    clr_req(0); clr_req(1);
    chk("t2_done", 64'(n_rsp[0] - b0 + n_rsp[1] - b1), 64'd8);
    chk("t2_grant_count", 64'(grant_q.size()), 64'd8);
    if (grant_q.size() >= 8) begin
      for (int j = 0; j < 8; j++) begin
        chk($sformatf("t2_grant%0d", j), 64'(grant_q[j]), 64'(j % 2));
        chk($sformatf("t2_issue_cycle%0d", j), 64'(acc_cyc_q[j] - acc_cyc_q[0]), 64'(j));
      end
    end

    // Backpressure on rsp0: second op stalls in S1, blocking req1 as well.
    chk_lat = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    b0 = n_acc[0];
    set_req(0, 32'd9, 32'd9, ALU_SUB, 4'd1);
    wait_cnt("t3_acc1", 1'b0, 0, b0 + 1, 10);
    set_req(0, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 4'd2);
    wait_cnt("t3_acc2", 1'b0, 0, b0 + 2, 10);
    clr_req(0);
    b1 = n_acc[1];
    set_req(1, 32'd1, 32'd2, ALU_ADD, 4'd5);
    repeat (5) begin
      #3;
      chk("t3_req0_ready", req0_ready, 1'b0);
      chk("t4_req1_ready", req1_ready, 1'b0);
      chk("t3_rsp0_valid", rsp0_valid, 1'b1);
      chk("t3_held_result", rsp0_result, 32'd0);
      chk("t3_held_zero", rsp0_zero, 1'b1);
      chk("t4_req1_blocked", 64'(n_acc[1]), 64'(b1));
      @(negedge clk);
    end
    b0 = n_rsp[0];
    rsp0_ready = 1'b1;
    wait_cnt("t3_rsp", 1'b1, 0, b0 + 2, 10);
    chk("t3_result2", last_res[0], 32'd1);
    chk("t3_zero2", last_zero[0], 1'b0);
    chk("t3_tag2", last_tag[0], 4'd2);
    wait_cnt("t4_acc", 1'b0, 1, b1 + 1, 10);
    clr_req(1);
    wait_cnt("t4_rsp", 1'b1, 1, n_acc[1], 10);

    // Reset with S1 and R1 both occupied.
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    b1 = n_acc[1];
    set_req(1, 32'd3, 32'd4, ALU_OR, 4'd6);
    wait_cnt("t5_acc1", 1'b0, 1, b1 + 1, 10);
    set_req(1, 32'd5, 32'd6, ALU_AND, 4'd7);
    wait_cnt("t5_acc2", 1'b0, 1, b1 + 2, 10);
    clr_req(1);
    #3;
    chk("t5_pre_busy", idle, 1'b0);
    chk("t5_pre_rsp1", rsp1_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 32'h8000_0000, 32'd4, ALU_SRA, 4'd9);
    set_req(1, 32'd1, 32'd31, ALU_SLL, 4'd10);
    #3;
    chk("t5_rst_req0_ready", req0_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    grant_q.delete();
    #3;
    chk("t5_idle", idle, 1'b1);
    chk("t5_rsp0_valid", rsp0_valid, 1'b0);
    chk("t5_rsp1_valid", rsp1_valid, 1'b0);
    @(negedge clk);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    b0 = n_acc[0]; b1 = n_acc[1];
    wait_cnt("t5_acc_r0", 1'b0, 0, b0 + 1, 10);
    clr_req(0);
    wait_cnt("t5_acc_r1", 1'b0, 1, b1 + 1, 10);
    clr_req(1);
    chk("t5_first_grant", 64'(grant_q.size() > 0 ? grant_q[0] : 9), 64'd0);
    wait_cnt("t5_rsp0", 1'b1, 0, n_acc[0], 10);
    wait_cnt("t5_rsp1", 1'b1, 1, n_acc[1], 10);

    // Random traffic on all four channels.
    b0 = n_acc[0] + n_acc[1]; k = 0;
    while (n_acc[0] + n_acc[1] < b0 + 10000 && k < 60000) begin
      for (int i = 0; i < 2; i++) begin
        if (acc_last[i] || !((i == 0) ? req0_valid : req1_valid)) begin
          if ($urandom_range(3) != 0)
            set_req(i, rnd_opnd(), rnd_opnd(), alu_op_t'(4'($urandom_range(15))),
                    4'($urandom_range(15)));
          else
            clr_req(i);
        end
      end
      rsp0_ready = ($urandom_range(3) != 0);
      rsp1_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      k++;
    end
    chk("t6_op_count", 64'(n_acc[0] + n_acc[1] >= b0 + 10000), 64'd1);
    clr_req(0); clr_req(1);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    k = 0;
    while ((n_rsp[0] != n_acc[0] || n_rsp[1] != n_acc[1]) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t6_drain0", 64'(n_rsp[0]), 64'(n_acc[0]));
    chk("t6_drain1", 64'(n_rsp[1]), 64'(n_acc[1]));
    #3;
    chk("t6_idle", idle, 1'b1);
    chk("t6_q_empty", 64'(q0.size() + q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
